// File: rtl/nav_pkg.sv
// Shared codes for the rover motion sequencer: motor directions, command and
// status encodings, manual button patterns and the sequencer state type.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for a command; motors neutral; ready when not manual
// S_RUN    | executing STRAIGHT / TURN_RIGHT / TURN_LEFT with power ramp
// S_BRAKE  | motors neutral for SETTLE cycles after any command ends
// S_REPORT | one cycle that raises DONE and publishes STATUS
package nav_pkg;

    localparam logic [1:0] DIR_FWD = 2'b00;
    localparam logic [1:0] DIR_NEU = 2'b01;
    localparam logic [1:0] DIR_REV = 2'b10;

    localparam logic [1:0] CMD_STOP     = 2'b00;
    localparam logic [1:0] CMD_STRAIGHT = 2'b01;
    localparam logic [1:0] CMD_TURN_R   = 2'b10;
    localparam logic [1:0] CMD_TURN_L   = 2'b11;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_STOPPED = 2'b10;

    localparam logic [4:0] BTN_PIVOT_R = 5'b00001;
    localparam logic [4:0] BTN_REV     = 5'b00010;
    localparam logic [4:0] BTN_FWD     = 5'b00100;
    localparam logic [4:0] BTN_PIVOT_L = 5'b01000;
    localparam logic [4:0] BTN_SPIN_R  = 5'b10000;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_BRAKE  = 2'd2,
        S_REPORT = 2'd3
    } nav_state_e;

endpackage

// File: rtl/nav_power_ramp.sv
// Soft-start power ramp shared by both tracks. The level climbs one step every
// RAMP_DIV enabled cycles while below the selected power and drops straight to
// the selected power if the selection falls below it. The next-cycle level is
// exported so the registered motor outputs show each step on the same edge the
// ramp register takes it.
module nav_power_ramp #(
    parameter int PW       = 3,
    parameter int RAMP_DIV = 1000
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [PW-1:0] pwr_sel_i,
    output logic [PW-1:0] level_nxt_o
);

    localparam int            CW       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(RAMP_DIV - 1);

    logic [CW-1:0] div_q, div_d;
    logic [PW-1:0] level_q, level_d;

    // Prescaler and level update; clamp wins over a pending step.
    always_comb begin
        div_d   = div_q;
        level_d = level_q;
        if (clr_i) begin
            div_d   = '0;
            level_d = '0;
        end else begin
            if (en_i) begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (level_q < pwr_sel_i) begin
                        level_d = level_q + PW'(1);
                    end
                end else begin
                    div_d = div_q + CW'(1);
                end
            end
            if (level_q > pwr_sel_i) begin
                level_d = pwr_sel_i;
            end
        end
    end

    // Ramp state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q   <= '0;
            level_q <= '0;
        end else begin
            div_q   <= div_d;
            level_q <= level_d;
        end
    end

    assign level_nxt_o = level_d;

endmodule

// File: rtl/nav_motion_sequencer.sv
// Command-driven motion sequencer for the two-track rover. Accepts one command
// at a time, drives MC1 (right) / MC2 (left) with ramped power, side-wall trim
// and turn-completion detection, brakes for SETTLE cycles, then pulses DONE.
// A manual override forces the sequencer idle and drives the tracks from the
// button pattern at the selected power.
module nav_motion_sequencer
    import nav_pkg::*;
#(
    parameter int DW       = 8,
    parameter int PW       = 3,
    parameter int RAMP_DIV = 1000,
    parameter int TURN_TOL = 10,
    parameter int TRIM_DB  = 1,
    parameter int SETTLE   = 50000,
    parameter int TIMEOUT  = 2**24-1
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          MANUAL,
    input  logic [4:0]    BTN,
    input  logic [PW-1:0] PWR_SEL,
    input  logic          CMD_VALID,
    input  logic [1:0]    CMD,
    input  logic [DW-1:0] DIST_TARGET,
    output logic          CMD_READY,
    input  logic [DW-1:0] DIST_FRONT,
    input  logic [DW-1:0] DIST_SIDE_FRONT,
    input  logic [DW-1:0] DIST_SIDE_BACK,
    output logic [PW+1:0] MC1,
    output logic [PW+1:0] MC2,
    output logic          DONE,
    output logic [1:0]    STATUS
);

    localparam int            TW          = $clog2(TIMEOUT + 1);
    localparam int            SW          = $clog2(SETTLE + 1);
    localparam logic [TW-1:0] RUN_LAST    = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [PW+1:0] MC_NEUTRAL  = {{PW{1'b0}}, DIR_NEU};

    nav_state_e    state_q;
    logic [1:0]    cmd_q;
    logic [DW-1:0] tgt_q;
    logic [TW-1:0] run_cnt_q;
    logic [SW-1:0] settle_cnt_q;
    logic [1:0]    pend_q;
    logic [1:0]    status_q;
    logic          done_q;
    logic          ready_q;
    logic [PW+1:0] mc1_q, mc1_d;
    logic [PW+1:0] mc2_q, mc2_d;

    logic [PW-1:0] ramp_nxt;
    logic [PW-1:0] boost;
    logic [DW-1:0] side_diff;
    logic          trim_on;
    logic          boost_mc1;
    logic          boost_mc2;
    logic          run_done;
    logic          timeout_hit;
    logic          accept;

    nav_power_ramp #(
        .PW       (PW),
        .RAMP_DIV (RAMP_DIV)
    ) u_ramp (
        .clk_i       (CLK),
        .rst_ni      (RST_N),
        .clr_i       (state_q != S_RUN),
        .en_i        (state_q == S_RUN),
        .pwr_sel_i   (PWR_SEL),
        .level_nxt_o (ramp_nxt)
    );

    assign side_diff = (DIST_SIDE_FRONT > DIST_SIDE_BACK) ? (DIST_SIDE_FRONT - DIST_SIDE_BACK)
                                                          : (DIST_SIDE_BACK - DIST_SIDE_FRONT);
    assign trim_on   = side_diff > DW'(TRIM_DB);
    assign boost_mc1 = trim_on && (DIST_SIDE_FRONT > DIST_SIDE_BACK);
    assign boost_mc2 = trim_on && (DIST_SIDE_FRONT < DIST_SIDE_BACK);
    assign boost     = (&ramp_nxt) ? ramp_nxt : ramp_nxt + PW'(1);

    // Turn check is widened by one bit so front + tolerance cannot wrap.
    assign run_done    = (cmd_q == CMD_STRAIGHT)
                       ? (DIST_FRONT <= tgt_q)
                       : (({1'b0, DIST_FRONT} + (DW+1)'(TURN_TOL)) >= {1'b0, tgt_q});
    assign timeout_hit = (run_cnt_q == RUN_LAST);
    assign accept      = CMD_VALID && ready_q;

    // Motor drive for the next edge: manual buttons override, else RUN command.
    always_comb begin
        mc1_d = MC_NEUTRAL;
        mc2_d = MC_NEUTRAL;
        if (MANUAL) begin
            mc1_d = {PWR_SEL, DIR_NEU};
            mc2_d = {PWR_SEL, DIR_NEU};
            case (BTN)
                BTN_PIVOT_R: mc2_d = {PWR_SEL, DIR_FWD};
                BTN_REV: begin
                    mc1_d = {PWR_SEL, DIR_REV};
                    mc2_d = {PWR_SEL, DIR_REV};
                end
                BTN_FWD: begin
                    mc1_d = {PWR_SEL, DIR_FWD};
                    mc2_d = {PWR_SEL, DIR_FWD};
                end
                BTN_PIVOT_L: mc1_d = {PWR_SEL, DIR_FWD};
                BTN_SPIN_R: begin
                    mc1_d = {PWR_SEL, DIR_REV};
                    mc2_d = {PWR_SEL, DIR_FWD};
                end
                default: ;
            endcase
        end else if (state_q == S_RUN) begin
            case (cmd_q)
                CMD_STRAIGHT: begin
                    mc1_d = {(boost_mc1 ? boost : ramp_nxt), DIR_FWD};
                    mc2_d = {(boost_mc2 ? boost : ramp_nxt), DIR_FWD};
                end
                CMD_TURN_R: begin
                    mc1_d = {ramp_nxt, DIR_REV};
                    mc2_d = {ramp_nxt, DIR_FWD};
                end
                CMD_TURN_L: begin
                    mc1_d = {ramp_nxt, DIR_FWD};
                    mc2_d = {ramp_nxt, DIR_REV};
                end
                default: ;
            endcase
        end
    end

    // Sequencer FSM with its counters and all registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            cmd_q        <= CMD_STOP;
            tgt_q        <= '0;
            run_cnt_q    <= '0;
            settle_cnt_q <= '0;
            pend_q       <= ST_OK;
            status_q     <= ST_OK;
            done_q       <= 1'b0;
            ready_q      <= 1'b0;
            mc1_q        <= MC_NEUTRAL;
            mc2_q        <= MC_NEUTRAL;
        end else begin
            mc1_q   <= mc1_d;
            mc2_q   <= mc2_d;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            if (MANUAL) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        settle_cnt_q <= '0;
                        if (accept) begin
                            cmd_q     <= CMD;
                            tgt_q     <= DIST_TARGET;
                            run_cnt_q <= '0;
                            if (CMD == CMD_STOP) begin
                                state_q <= S_BRAKE;
                                pend_q  <= ST_STOPPED;
                            end else begin
                                state_q <= S_RUN;
                            end
                        end else begin
                            ready_q <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        run_cnt_q    <= run_cnt_q + TW'(1);
                        settle_cnt_q <= '0;
                        if (timeout_hit) begin
                            state_q <= S_BRAKE;
                            pend_q  <= ST_TIMEOUT;
                        end else if (run_done) begin
                            state_q <= S_BRAKE;
                            pend_q  <= ST_OK;
                        end
                    end
                    S_BRAKE: begin
                        if (settle_cnt_q == SETTLE_LAST) begin
                            state_q <= S_REPORT;
                        end else begin
                            settle_cnt_q <= settle_cnt_q + SW'(1);
                        end
                    end
                    S_REPORT: begin
                        done_q   <= 1'b1;
                        status_q <= pend_q;
                        state_q  <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign CMD_READY = ready_q;
    assign MC1       = mc1_q;
    assign MC2       = mc2_q;
    assign DONE      = done_q;
    assign STATUS    = status_q;

endmodule

// File: tb/tb_nav_motion_sequencer.sv
// Bench for nav_motion_sequencer: a timeline model (phase derived from the
// accept/end edge numbers) checked every cycle, plus literal spot checks.
module tb_nav_motion_sequencer;

    localparam int RAMP_DIV = 4;
    localparam int SETTLE   = 3;
    localparam int TIMEOUT  = 100;
    localparam int TURN_TOL = 10;
    localparam int TRIM_DB  = 1;

    localparam logic [1:0] D_FWD = 2'b00;
    localparam logic [1:0] D_NEU = 2'b01;
    localparam logic [1:0] D_REV = 2'b10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       manual;
    logic [4:0] btn;
    logic [2:0] pwr_sel;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic [7:0] tgt;
    logic       ready;
    logic [7:0] front, sf, sb;
    logic [4:0] mc1, mc2;
    logic       done;
    logic [1:0] status;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nav_motion_sequencer #(
        .DW(8), .PW(3), .RAMP_DIV(RAMP_DIV), .TURN_TOL(TURN_TOL),
        .TRIM_DB(TRIM_DB), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK             (clk),
        .RST_N           (rst_n),
        .MANUAL          (manual),
        .BTN             (btn),
        .PWR_SEL         (pwr_sel),
        .CMD_VALID       (cmd_valid),
        .CMD             (cmd),
        .DIST_TARGET     (tgt),
        .CMD_READY       (ready),
        .DIST_FRONT      (front),
        .DIST_SIDE_FRONT (sf),
        .DIST_SIDE_BACK  (sb),
        .MC1             (mc1),
        .MC2             (mc2),
        .DONE            (done),
        .STATUS          (status)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [4:0] x_mc1, x_mc2;
    logic       x_done, x_ready;
    logic [1:0] x_status;
    int         m_e, m_tend, m_k, m_p, m_ph, m_ps, m_dd, m_p1, m_p2;
    bit         m_busy, m_acc, m_fin;
    logic [1:0] m_cmd, m_pend, m_d1, m_d2;
    logic [7:0] m_tgt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_e = 0; m_tend = -1; m_k = 0; m_p = 0; m_busy = 0;
            m_cmd = 2'b00; m_pend = 2'b00; m_tgt = 8'd0;
            x_mc1 = 5'b00001; x_mc2 = 5'b00001;
            x_done = 1'b0; x_ready = 1'b0; x_status = 2'b00;
        end else begin
            m_e++;
            // phase after the previous edge, from the command's timeline
            if (!m_busy) m_ph = 0;
            else if (m_tend < 0) m_ph = 1;
            else if (m_e - 1 < m_tend + SETTLE) m_ph = 2;
            else m_ph = 3;
            m_ps = int'(pwr_sel);
            if (m_ph == 1) begin
                m_k++;
                if ((m_k % RAMP_DIV) == 0 && m_p < m_ps) m_p++;
                else if (m_p > m_ps) m_p = m_ps;
            end
            m_p1 = 0; m_p2 = 0; m_d1 = D_NEU; m_d2 = D_NEU;
            if (manual) begin
                m_p1 = m_ps; m_p2 = m_ps;
                case (btn)
                    5'b00001: m_d2 = D_FWD;
                    5'b00010: begin m_d1 = D_REV; m_d2 = D_REV; end
                    5'b00100: begin m_d1 = D_FWD; m_d2 = D_FWD; end
                    5'b01000: m_d1 = D_FWD;
                    5'b10000: begin m_d1 = D_REV; m_d2 = D_FWD; end
                    default: ;
                endcase
            end else if (m_ph == 1) begin
                m_p1 = m_p; m_p2 = m_p;
                if (m_cmd == 2'b01) begin
                    m_d1 = D_FWD; m_d2 = D_FWD;
                    m_dd = int'(sf) - int'(sb);
                    if (m_dd < 0) m_dd = -m_dd;
                    if (m_dd > TRIM_DB) begin
                        if (sf < sb) m_p2 = (m_p + 1 > 7) ? 7 : m_p + 1;
                        else         m_p1 = (m_p + 1 > 7) ? 7 : m_p + 1;
                    end
                end else if (m_cmd == 2'b10) begin
                    m_d1 = D_REV; m_d2 = D_FWD;
                end else if (m_cmd == 2'b11) begin
                    m_d1 = D_FWD; m_d2 = D_REV;
                end
            end
            x_mc1 = {m_p1[2:0], m_d1};
            x_mc2 = {m_p2[2:0], m_d2};
            x_done = (m_ph == 3) && !manual;
            if (x_done) x_status = m_pend;
            m_acc = 0;
            if (manual) begin
                m_busy = 0;
            end else begin
                case (m_ph)
                    0: if (cmd_valid && x_ready) begin
                        m_acc = 1; m_busy = 1; m_cmd = cmd; m_tgt = tgt; m_k = 0; m_p = 0;
                        if (cmd == 2'b00) begin m_tend = m_e; m_pend = 2'b10; end
                        else m_tend = -1;
                    end
                    1: begin
                        if (m_cmd == 2'b01) m_fin = int'(front) <= int'(m_tgt);
                        else m_fin = int'(front) + TURN_TOL >= int'(m_tgt);
                        if (m_k == TIMEOUT) begin m_tend = m_e; m_pend = 2'b01; end
                        else if (m_fin) begin m_tend = m_e; m_pend = 2'b00; end
                    end
                    3: m_busy = 0;
                    default: ;
                endcase
            end
            x_ready = !manual && (m_ph == 0) && !m_acc;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("model_mc1", mc1, x_mc1);
            chk("model_mc2", mc2, x_mc2);
            chk("model_done", done, x_done);
            chk("model_status", status, x_status);
            chk("model_ready", ready, x_ready);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c, input logic [7:0] t);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 20) begin tick(); n++; end
        if (ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL send_ready got %b want 1", ready);
        end
        cmd = c; tgt = t; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int n;
        n = 0;
        while (done !== 1'b1 && n < maxc) begin tick(); n++; end
        if (done !== 1'b1) begin
            checks++; errors++;
            $display("FAIL wait_done got %b want 1 within %0d cycles", done, maxc);
        end
    endtask

    logic [4:0] btn_tab [6] = '{5'b00001, 5'b00010, 5'b01000, 5'b10000, 5'b00011, 5'b00000};
    logic [4:0] m1_tab  [6] = '{5'b10101, 5'b10110, 5'b10100, 5'b10110, 5'b10101, 5'b10101};
    logic [4:0] m2_tab  [6] = '{5'b10100, 5'b10110, 5'b10101, 5'b10100, 5'b10101, 5'b10101};

    initial begin
        int pw;
        logic [2:0] pw3;
        rst_n = 1'b0; manual = 1'b0; btn = 5'b0; pwr_sel = 3'd0;
        cmd_valid = 1'b0; cmd = 2'b00; tgt = 8'd0;
        front = 8'd200; sf = 8'd50; sb = 8'd50;
        repeat (2) tick();
        chk("rst_mc1", mc1, 5'b00001);
        chk("rst_mc2", mc2, 5'b00001);
        chk("rst_ready", ready, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_status", status, 2'b00);
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", ready, 1'b1);

        // soft start, clamp on decrease, PWR_SEL=0
        pwr_sel = 3'd5;
        send(2'b01, 8'd20);
        for (int j = 1; j <= 30; j++) begin
            tick();
            pw  = (j / 4 > 5) ? 5 : j / 4;
            pw3 = pw[2:0];
            chk("soft_start_mc1", mc1, {pw3, 2'b00});
            chk("soft_start_mc2", mc2, {pw3, 2'b00});
        end
        pwr_sel = 3'd2; tick();
        chk("clamp_mc1", mc1, 5'b01000);
        pwr_sel = 3'd0; tick();
        chk("zero_sel_mc1", mc1, 5'b00000);
        front = 8'd20;
        wait_done(20);
        chk("soft_status", status, 2'b00);

        // straight stop with trim
        pwr_sel = 3'd5; front = 8'd200; sf = 8'd10; sb = 8'd14;
        send(2'b01, 8'd20);
        repeat (10) tick();
        chk("trim_mc1", mc1, 5'b01000);
        chk("trim_mc2", mc2, 5'b01100);
        front = 8'd20;
        tick();
        chk("stop_edge_mc2", mc2, 5'b01100);
        tick();
        chk("stop_neutral_mc1", mc1, 5'b00001);
        chk("stop_neutral_mc2", mc2, 5'b00001);
        repeat (2) tick();
        chk("stop_done_early", done, 1'b0);
        tick();
        chk("stop_done", done, 1'b1);
        chk("stop_status", status, 2'b00);

        // trim boost saturates at all-ones
        pwr_sel = 3'd7; front = 8'd200;
        send(2'b01, 8'd20);
        repeat (32) tick();
        chk("sat_mc1", mc1, 5'b11100);
        chk("sat_mc2", mc2, 5'b11100);
        front = 8'd0;
        wait_done(20);

        // turn right with saturation and tolerance boundary
        sf = 8'd50; sb = 8'd50; front = 8'd85;
        send(2'b10, 8'd100);
        repeat (32) tick();
        chk("turn_r_mc1", mc1, 5'b11110);
        chk("turn_r_mc2", mc2, 5'b11100);
        front = 8'd90;
        repeat (2) tick();
        chk("turn_end_mc1", mc1, 5'b00001);
        chk("turn_end_mc2", mc2, 5'b00001);
        wait_done(20);
        chk("turn_status", status, 2'b00);

        // turn left mirror
        front = 8'd50;
        send(2'b11, 8'd100);
        repeat (4) tick();
        chk("turn_l_mc1", mc1, 5'b11100 & 5'b00100);
        chk("turn_l_mc2", mc2, 5'b00110);
        front = 8'd95;
        wait_done(20);

        // STOP command
        send(2'b00, 8'd0);
        repeat (3) tick();
        chk("stop_cmd_done_early", done, 1'b0);
        tick();
        chk("stop_cmd_done", done, 1'b1);
        chk("stop_cmd_status", status, 2'b10);

        // completion on RUN cycle 99 is not a timeout
        pwr_sel = 3'd3; front = 8'd200;
        send(2'b01, 8'd20);
        repeat (98) tick();
        front = 8'd20; tick(); front = 8'd200;
        repeat (4) tick();
        chk("c99_done", done, 1'b1);
        chk("c99_status", status, 2'b00);

        // pure timeout
        send(2'b01, 8'd20);
        repeat (100) tick();
        chk("to_last_run_mc1", mc1, 5'b01100);
        tick();
        chk("to_neutral_mc1", mc1, 5'b00001);
        repeat (3) tick();
        chk("to_done", done, 1'b1);
        chk("to_status", status, 2'b01);

        // timeout and completion on the same cycle
        send(2'b01, 8'd20);
        repeat (99) tick();
        front = 8'd20; tick(); front = 8'd200;
        repeat (4) tick();
        chk("to_prio_done", done, 1'b1);
        chk("to_prio_status", status, 2'b01);

        // manual abort mid-RUN
        pwr_sel = 3'd5;
        send(2'b01, 8'd20);
        repeat (10) tick();
        manual = 1'b1; btn = 5'b00100;
        tick();
        chk("man_fwd_mc1", mc1, 5'b10100);
        chk("man_fwd_mc2", mc2, 5'b10100);
        chk("man_ready", ready, 1'b0);
        for (int i = 0; i < 6; i++) begin
            btn = btn_tab[i];
            tick();
            chk("man_btn_mc1", mc1, m1_tab[i]);
            chk("man_btn_mc2", mc2, m2_tab[i]);
            chk("man_no_done", done, 1'b0);
        end
        manual = 1'b0; btn = 5'b0;
        tick();
        chk("man_exit_ready", ready, 1'b1);
        chk("man_status_held", status, 2'b01);
        chk("man_exit_mc1", mc1, 5'b00001);

        // reset mid-RUN is asynchronous
        send(2'b01, 8'd20);
        repeat (12) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mc1", mc1, 5'b00001);
        chk("arst_mc2", mc2, 5'b00001);
        chk("arst_ready", ready, 1'b0);
        chk("arst_status", status, 2'b00);
        repeat (2) tick();
        #2 rst_n = 1'b1;
        tick();
        chk("arst_release_ready", ready, 1'b1);
        chk("arst_release_done", done, 1'b0);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
